// File: rtl/connection_status_toe_pkg.sv
// Shared types and defaults for the connect-status return path.
package connection_status_toe_pkg;

  localparam int HOST_ADDR_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;
  localparam int DEF_BACKOFF_CYCLES  = 16;
  localparam int DEF_MAX_RETRY       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_UP      = 2'd3
  } conn_state_e;

endpackage

// File: rtl/connection_status_toe_if.sv
// Request/status/result bundle between the API, the TOE status path and the tracker.
interface connection_status_toe_if
  import connection_status_toe_pkg::*;
#(
  parameter int HOST_ADDR = HOST_ADDR_WIDTH
);
  logic                 req_i;
  logic [HOST_ADDR-1:0] req_addr_i;
  logic                 status_valid_i;
  logic                 status_ok_i;
  logic [HOST_ADDR-1:0] status_addr_i;
  logic                 close_i;
  logic                 retry_o;
  logic [HOST_ADDR-1:0] retry_addr_o;
  logic                 connected_o;
  logic [HOST_ADDR-1:0] connected_addr_o;
  logic                 done_o;
  logic                 fail_o;
  logic                 closed_o;
  logic                 busy_o;

  modport slave (
    input  req_i, req_addr_i, status_valid_i, status_ok_i, status_addr_i, close_i,
    output retry_o, retry_addr_o, connected_o, connected_addr_o,
           done_o, fail_o, closed_o, busy_o
  );

  modport master (
    output req_i, req_addr_i, status_valid_i, status_ok_i, status_addr_i, close_i,
    input  retry_o, retry_addr_o, connected_o, connected_addr_o,
           done_o, fail_o, closed_o, busy_o
  );
endinterface

// File: rtl/connection_status_toe_conn_timer.sv
// Clearable saturating up-counter with a terminal-count flag, shared by timeout and backoff.
module connection_status_toe_conn_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == term_i);

endmodule

// File: rtl/connection_status_toe.sv
// Tracks each connect request toward the TOE: waits for status, retries with backoff, reports result.
module connection_status_toe
  import connection_status_toe_pkg::*;
#(
  parameter int HOST_ADDR      = HOST_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input logic                    clk,
  input logic                    rst,
  connection_status_toe_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  conn_state_e          state_q, state_d;
  logic [HOST_ADDR-1:0] addr_q, addr_d;
  logic [RW-1:0]        retry_cnt_q, retry_cnt_d;
  logic                 retry_q, retry_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 closed_q, closed_d;
  logic                 connected_q, connected_d;
  logic                 busy_q, busy_d;

  logic          timer_clr, timer_en, timer_tc;
  logic [TW-1:0] timer_term;
  logic          status_match;

  assign status_match = bus.status_valid_i && (bus.status_addr_i == addr_q);

  connection_status_toe_conn_timer #(
    .WIDTH (TW)
  ) u_conn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timer_clr),
    .en_i    (timer_en),
    .term_i  (timer_term),
    .tc_o    (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    retry_cnt_d = retry_cnt_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    timer_term  = TW'(TIMEOUT_CYCLES - 1);
    retry_d     = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    closed_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          addr_d      = bus.req_addr_i;
          retry_cnt_d = '0;
          timer_clr   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        // A matching status outranks a simultaneous timeout.
        if (status_match && bus.status_ok_i) begin
          done_d  = 1'b1;
          state_d = ST_UP;
        end else if (status_match || timer_tc) begin
          if (retry_cnt_q < RW'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            timer_clr   = 1'b1;
            state_d     = ST_BACKOFF;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BACKOFF: begin
        timer_en   = 1'b1;
        timer_term = TW'(BACKOFF_CYCLES - 1);
        if (timer_tc) begin
          retry_d   = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_UP: begin
        if (bus.close_i) begin
          closed_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_WAIT) || (state_d == ST_BACKOFF);
    connected_d = (state_d == ST_UP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      retry_cnt_q <= '0;
      retry_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      closed_q    <= 1'b0;
      connected_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      retry_cnt_q <= retry_cnt_d;
      retry_q     <= retry_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      closed_q    <= closed_d;
      connected_q <= connected_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.retry_o          = retry_q;
  assign bus.retry_addr_o     = addr_q;
  assign bus.connected_o      = connected_q;
  assign bus.connected_addr_o = addr_q;
  assign bus.done_o           = done_q;
  assign bus.fail_o           = fail_q;
  assign bus.closed_o         = closed_q;
  assign bus.busy_o           = busy_q;

endmodule
